diff_core_loader: RTL and testbench
===================================

DIFF_CORE_LOADER -- requirements
Module: diff_core_loader

Interface
REQ-001 Parameter CONF_PE_COL, default 4, number of PE columns (feature-map and guard buffer pairs).
REQ-002 Parameter CONF_FM_BUF_DEPTH, default 256, words per column feature-map buffer; FAW = $clog2(CONF_FM_BUF_DEPTH).
REQ-003 Parameter CONF_GUARD_BUF_DEPTH, default 64, words per column guard buffer; GAW = $clog2(CONF_GUARD_BUF_DEPTH).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load+run job; sampled only in IDLE.
REQ-007 fm_words_i  input  FAW+1  feature-map words per column (0..CONF_FM_BUF_DEPTH), latched on start.
REQ-008 gd_words_i  input  GAW+1  guard words per column (0..CONF_GUARD_BUF_DEPTH), latched on start.
REQ-009 bit_mode_i, is_diff_i  input  1 each  job mode bits, latched on start.
REQ-010 s_valid  input  1 / s_ready  output  1 / s_data  input  72  upstream word stream; beat accepted when s_valid && s_ready.
REQ-011 load_fm_wr_addr  output  [CONF_PE_COL][FAW]  feature-map write address, same value on every column.
REQ-012 load_fm_din  output  [CONF_PE_COL][72]  feature-map write data, same value on every column.
REQ-013 load_fm_wr_en  output  CONF_PE_COL  feature-map write enable, at most one bit high.
REQ-014 load_gd_wr_addr [CONF_PE_COL][GAW], load_gd_din [CONF_PE_COL][72], load_gd_wr_en CONF_PE_COL  outputs  guard write port, same rules as REQ-011..013.
REQ-015 core_valid  output  1 / core_ready  input  1 / core_finish  input  1  core launch handshake and completion pulse.
REQ-016 core_bit_mode_i, core_is_diff_i  output  1 each  latched mode bits driven to the core.
REQ-017 busy  output  1  high in any state other than IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-018 FSM states IDLE, LOAD_FM, LOAD_GD, LAUNCH, RUN.
REQ-019 IDLE: on start, latch counts and mode bits, clear col/addr counters, go to LOAD_FM; if fm count is 0 go to LOAD_GD; if both counts are 0 go to LAUNCH.
REQ-020 s_ready SHALL be 1 exactly in LOAD_FM and LOAD_GD (registered state decode, no dependency on s_valid).
REQ-021 Ordering is column-major: beat k of a phase goes to column k / N, address k mod N (N = latched count for that phase).
REQ-022 Per accepted beat: addr increments; when addr == N-1 it wraps to 0 and col increments; the beat with col == CONF_PE_COL-1 and addr == N-1 ends the phase.
REQ-023 End of LOAD_FM -> LOAD_GD (or LAUNCH if gd count is 0); end of LOAD_GD -> LAUNCH.
REQ-024 Write outputs SHALL be registered: an accepted beat appears on din/addr with its wr_en bit high exactly one cycle later, for one cycle only; wr_en is 0 in every cycle without an accepted beat in the prior cycle.
REQ-025 No-accept cycles (s_valid low) SHALL stall the counters with no write.
REQ-026 LAUNCH: core_valid = 1, held until core_valid && core_ready, then go to RUN with core_valid = 0 the following cycle.
REQ-027 RUN: on core_finish go to IDLE, done = 1 for that one cycle; core_finish in any other state is ignored.
REQ-028 start while busy is ignored; latched counts and mode bits are stable from start to done.
REQ-029 Counts above the buffer depth are clamped to the depth when latched.

Reset
REQ-030 rst SHALL asynchronously force IDLE, counters 0, s_ready 0, all wr_en 0, wr_addr 0, din 0, core_valid 0, core_bit_mode_i 0, core_is_diff_i 0, busy 0, done 0.
REQ-031 Reset mid-job SHALL abandon the job with no further writes; words already written are not restored.

Verification
REQ-032 fm=2, gd=1, stream 12 beats D0..D11 with s_valid always high -> fm writes col0 a0/a1 = D0/D1 ... col3 a1 = D7; gd col0..3 a0 = D8..D11; core_valid rises the cycle after the D11 write.
REQ-033 Same job with s_valid toggling every other cycle -> identical write sequence; no wr_en in the stall cycles; one-cycle write latency holds.
REQ-034 fm=0, gd=0 -> LAUNCH directly after start, no writes, s_ready never high; core_ready held low for 5 cycles -> core_valid stays high for all 5.
REQ-035 core_finish pulsed during LOAD_FM and again in RUN -> first ignored; second gives done=1 for one cycle and busy=0 the next cycle.
REQ-036 rst asserted after 3 of 8 fm beats -> all outputs at reset values immediately; a new start then restarts at col0 a0.
REQ-037 start pulsed during RUN with different counts -> ignored; the next job after done uses the newly sampled values.

Source files
------------

// File: rtl/diff_core_loader.sv
// diff_core_loader
// Streams feature-map and guard words from a single 72-bit upstream channel
// into per-column buffers (column-major), then launches the compute core and
// waits for its completion pulse. Write ports are fully registered.
module diff_core_loader #(
  parameter int CONF_PE_COL          = 4,
  parameter int CONF_FM_BUF_DEPTH    = 256,
  parameter int CONF_GUARD_BUF_DEPTH = 64,
  localparam int FAW = $clog2(CONF_FM_BUF_DEPTH),
  localparam int GAW = $clog2(CONF_GUARD_BUF_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [FAW:0]                      fm_words_i,
  input  logic [GAW:0]                      gd_words_i,
  input  logic                              bit_mode_i,
  input  logic                              is_diff_i,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [71:0]                       s_data,
  output logic [CONF_PE_COL-1:0][FAW-1:0]   load_fm_wr_addr,
  output logic [CONF_PE_COL-1:0][71:0]      load_fm_din,
  output logic [CONF_PE_COL-1:0]            load_fm_wr_en,
  output logic [CONF_PE_COL-1:0][GAW-1:0]   load_gd_wr_addr,
  output logic [CONF_PE_COL-1:0][71:0]      load_gd_din,
  output logic [CONF_PE_COL-1:0]            load_gd_wr_en,
  output logic                              core_valid,
  input  logic                              core_ready,
  input  logic                              core_finish,
  output logic                              core_bit_mode_i,
  output logic                              core_is_diff_i,
  output logic                              busy,
  output logic                              done
);

  localparam int CW = (CONF_PE_COL > 1) ? $clog2(CONF_PE_COL) : 1;
  // One address counter serves both phases, so it is sized for the larger buffer.
  localparam int AW = (FAW > GAW) ? FAW : GAW;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_FM = 3'd1;
  localparam logic [2:0] ST_LOAD_GD = 3'd2;
  localparam logic [2:0] ST_LAUNCH  = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;

  // Column select decoded to a one-hot write-enable vector.
  function automatic logic [CONF_PE_COL-1:0] col_onehot(input logic [CW-1:0] col);
    logic [CONF_PE_COL-1:0] v;
    v      = {CONF_PE_COL{1'b0}};
    v[col] = 1'b1;
    return v;
  endfunction

  logic [2:0]             state_q, state_d;
  logic [FAW:0]           fm_n_q, fm_n_d;
  logic [GAW:0]           gd_n_q, gd_n_d;
  logic                   bit_mode_q, bit_mode_d;
  logic                   is_diff_q, is_diff_d;
  logic [CW-1:0]          col_q, col_d;
  logic [AW-1:0]          addr_q, addr_d;

  logic [CONF_PE_COL-1:0] fm_wr_en_q, fm_wr_en_d;
  logic [CONF_PE_COL-1:0] gd_wr_en_q, gd_wr_en_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [71:0]            din_q, din_d;

  logic                   s_ready_q;
  logic                   busy_q;
  logic                   core_valid_q;
  logic                   done_q;

  logic [FAW:0]           fm_clamp_s;
  logic [GAW:0]           gd_clamp_s;
  logic [AW:0]            phase_n_s;
  logic                   last_addr_s;
  logic                   last_col_s;
  logic                   accept_s;

  assign accept_s    = s_valid && s_ready_q;
  assign last_addr_s = ({1'b0, addr_q} == (phase_n_s - (AW+1)'(1)));
  assign last_col_s  = (col_q == CW'(CONF_PE_COL - 1));

  // Clamp requested word counts to the physical buffer depths.
  always_comb begin
    if (fm_words_i > (FAW+1)'(CONF_FM_BUF_DEPTH)) begin
      fm_clamp_s = (FAW+1)'(CONF_FM_BUF_DEPTH);
    end else begin
      fm_clamp_s = fm_words_i;
    end
    if (gd_words_i > (GAW+1)'(CONF_GUARD_BUF_DEPTH)) begin
      gd_clamp_s = (GAW+1)'(CONF_GUARD_BUF_DEPTH);
    end else begin
      gd_clamp_s = gd_words_i;
    end
  end

  // Words per column of the phase currently being loaded.
  always_comb begin
    if (state_q == ST_LOAD_GD) begin
      phase_n_s = (AW+1)'(gd_n_q);
    end else begin
      phase_n_s = (AW+1)'(fm_n_q);
    end
  end

  // Job FSM: latches the job on start, walks col/addr per accepted beat.
  always_comb begin
    state_d    = state_q;
    fm_n_d     = fm_n_q;
    gd_n_d     = gd_n_q;
    bit_mode_d = bit_mode_q;
    is_diff_d  = is_diff_q;
    col_d      = col_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fm_n_d     = fm_clamp_s;
          gd_n_d     = gd_clamp_s;
          bit_mode_d = bit_mode_i;
          is_diff_d  = is_diff_i;
          col_d      = {CW{1'b0}};
          addr_d     = {AW{1'b0}};
          if (fm_clamp_s != {(FAW+1){1'b0}}) begin
            state_d = ST_LOAD_FM;
          end else if (gd_clamp_s != {(GAW+1){1'b0}}) begin
            state_d = ST_LOAD_GD;
          end else begin
            state_d = ST_LAUNCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_FM, ST_LOAD_GD: begin
        if (accept_s) begin
          if (last_addr_s) begin
            addr_d = {AW{1'b0}};
            if (last_col_s) begin
              col_d = {CW{1'b0}};
              if ((state_q == ST_LOAD_FM) && (gd_n_q != {(GAW+1){1'b0}})) begin
                state_d = ST_LOAD_GD;
              end else begin
                state_d = ST_LAUNCH;
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LAUNCH: begin
        if (core_valid_q && core_ready) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_RUN: begin
        if (core_finish) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next write-port contents: an accepted beat is presented one cycle later.
  always_comb begin
    fm_wr_en_d = {CONF_PE_COL{1'b0}};
    gd_wr_en_d = {CONF_PE_COL{1'b0}};
    wr_addr_d  = wr_addr_q;
    din_d      = din_q;
    if (accept_s) begin
      wr_addr_d = addr_q;
      din_d     = s_data;
      if (state_q == ST_LOAD_FM) begin
        fm_wr_en_d = col_onehot(col_q);
      end else begin
        gd_wr_en_d = col_onehot(col_q);
      end
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  // FSM state, latched job parameters and the column/address counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fm_n_q     <= {(FAW+1){1'b0}};
      gd_n_q     <= {(GAW+1){1'b0}};
      bit_mode_q <= 1'b0;
      is_diff_q  <= 1'b0;
      col_q      <= {CW{1'b0}};
      addr_q     <= {AW{1'b0}};
    end else begin
      state_q    <= state_d;
      fm_n_q     <= fm_n_d;
      gd_n_q     <= gd_n_d;
      bit_mode_q <= bit_mode_d;
      is_diff_q  <= is_diff_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
    end
  end

  // Registered buffer write ports shared by every column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_wr_en_q <= {CONF_PE_COL{1'b0}};
      gd_wr_en_q <= {CONF_PE_COL{1'b0}};
      wr_addr_q  <= {AW{1'b0}};
      din_q      <= 72'd0;
    end else begin
      fm_wr_en_q <= fm_wr_en_d;
      gd_wr_en_q <= gd_wr_en_d;
      wr_addr_q  <= wr_addr_d;
      din_q      <= din_d;
    end
  end

  // Registered status and handshake outputs decoded from the next state.
  // core_valid is raised the cycle after LAUNCH is entered so the last
  // buffer write has already landed before the core is asked to start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      s_ready_q    <= (state_d == ST_LOAD_FM) || (state_d == ST_LOAD_GD);
      busy_q       <= (state_d != ST_IDLE);
      core_valid_q <= (state_q == ST_LAUNCH) && !(core_valid_q && core_ready);
      done_q       <= (state_q == ST_RUN) && core_finish;
    end
  end

  for (genvar c = 0; c < CONF_PE_COL; c++) begin : g_col
    assign load_fm_wr_addr[c] = wr_addr_q[FAW-1:0];
    assign load_fm_din[c]     = din_q;
    assign load_gd_wr_addr[c] = wr_addr_q[GAW-1:0];
    assign load_gd_din[c]     = din_q;
  end

  assign load_fm_wr_en   = fm_wr_en_q;
  assign load_gd_wr_en   = gd_wr_en_q;
  assign s_ready         = s_ready_q;
  assign busy            = busy_q;
  assign core_valid      = core_valid_q;
  assign done            = done_q;
  assign core_bit_mode_i = bit_mode_q;
  assign core_is_diff_i  = is_diff_q;

endmodule

// File: tb/tb_diff_core_loader.sv
// Directed bench for diff_core_loader: a table of load+run jobs plus
// hand-written sequences for launch back-pressure, ignored finish/start
// and mid-job reset.
module tb_diff_core_loader;

  localparam int PE  = 4;
  localparam int FAW = 8;
  localparam int GAW = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [FAW:0]           fm_words_i;
  logic [GAW:0]           gd_words_i;
  logic                   bit_mode_i;
  logic                   is_diff_i;
  logic                   s_valid;
  logic                   s_ready;
  logic [71:0]            s_data;
  logic [PE-1:0][FAW-1:0] load_fm_wr_addr;
  logic [PE-1:0][71:0]    load_fm_din;
  logic [PE-1:0]          load_fm_wr_en;
  logic [PE-1:0][GAW-1:0] load_gd_wr_addr;
  logic [PE-1:0][71:0]    load_gd_din;
  logic [PE-1:0]          load_gd_wr_en;
  logic                   core_valid;
  logic                   core_ready;
  logic                   core_finish;
  logic                   core_bit_mode_i;
  logic                   core_is_diff_i;
  logic                   busy;
  logic                   done;

  diff_core_loader #(
    .CONF_PE_COL(PE),
    .CONF_FM_BUF_DEPTH(256),
    .CONF_GUARD_BUF_DEPTH(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .fm_words_i(fm_words_i), .gd_words_i(gd_words_i),
    .bit_mode_i(bit_mode_i), .is_diff_i(is_diff_i),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load_fm_wr_addr(load_fm_wr_addr), .load_fm_din(load_fm_din), .load_fm_wr_en(load_fm_wr_en),
    .load_gd_wr_addr(load_gd_wr_addr), .load_gd_din(load_gd_din), .load_gd_wr_en(load_gd_wr_en),
    .core_valid(core_valid), .core_ready(core_ready), .core_finish(core_finish),
    .core_bit_mode_i(core_bit_mode_i), .core_is_diff_i(core_is_diff_i),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FAW:0] fm_in;
    logic [GAW:0] gd_in;
    logic         tog;
    logic         bm;
    logic         df;
    int           exp_fm_n;
    int           exp_gd_n;
  } job_t;

  job_t jobs [5];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] pat(input int k);
    return {8'h5A, 32'(k) ^ 32'hC0DE_0000, 32'(k * 7 + 1)};
  endfunction

  task automatic check_reset_outputs();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_fm_wr_en", load_fm_wr_en, 4'd0);
    chk("rst_gd_wr_en", load_gd_wr_en, 4'd0);
    for (int c = 0; c < PE; c++) begin
      chk("rst_fm_addr", load_fm_wr_addr[c], 8'd0);
      chk("rst_fm_din", load_fm_din[c], 72'd0);
      chk("rst_gd_addr", load_gd_wr_addr[c], 6'd0);
      chk("rst_gd_din", load_gd_din[c], 72'd0);
    end
    chk("rst_core_valid", core_valid, 1'b0);
    chk("rst_bit_mode", core_bit_mode_i, 1'b0);
    chk("rst_is_diff", core_is_diff_i, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
  endtask

  // Called at a negedge in IDLE; returns at the following negedge.
  task automatic start_job(input int fm, input int gd, input logic bm, input logic df);
    fm_words_i = (FAW+1)'(fm);
    gd_words_i = (GAW+1)'(gd);
    bit_mode_i = bm;
    is_diff_i  = df;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_bit_mode", core_bit_mode_i, bm);
    chk("start_is_diff", core_is_diff_i, df);
    chk("start_done", done, 1'b0);
  endtask

  // Streams beats 0..lim-1 of a job with fm_n/gd_n words per column and
  // checks every write, column-major, one cycle after its beat.
  task automatic run_stream(input int fm_n, input int gd_n, input bit tog, input int lim);
    int fm_tot, tot, k, pk, cyc, col, adr;
    bit pend;
    logic [PE-1:0] exp_fm_en, exp_gd_en;
    fm_tot = PE * fm_n;
    tot    = fm_tot + PE * gd_n;
    k = 0; pk = 0; cyc = 0; pend = 1'b0; col = 0; adr = 0;
    while ((k < lim) || pend) begin
      exp_fm_en = 4'd0;
      exp_gd_en = 4'd0;
      if (pend) begin
        if (pk < fm_tot) begin
          col = pk / fm_n; adr = pk % fm_n; exp_fm_en[col] = 1'b1;
        end else begin
          col = (pk - fm_tot) / gd_n; adr = (pk - fm_tot) % gd_n; exp_gd_en[col] = 1'b1;
        end
      end
      chk("fm_wr_en", load_fm_wr_en, exp_fm_en);
      chk("gd_wr_en", load_gd_wr_en, exp_gd_en);
      if (pend) begin
        for (int c = 0; c < PE; c++) begin
          if (pk < fm_tot) begin
            chk("fm_addr", load_fm_wr_addr[c], adr);
            chk("fm_din", load_fm_din[c], pat(pk));
          end else begin
            chk("gd_addr", load_gd_wr_addr[c], adr);
            chk("gd_din", load_gd_din[c], pat(pk));
          end
        end
      end
      chk("s_ready", s_ready, k < tot);
      chk("core_valid_early", core_valid, 1'b0);
      pend = 1'b0;
      if (k < lim) begin
        s_valid = tog ? (cyc % 2 == 0) : 1'b1;
        s_data  = pat(k);
        if (s_valid) begin
          pend = 1'b1; pk = k; k++;
        end
      end else begin
        s_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Entered at the first negedge where core_valid should be high.
  task automatic launch_job(input int delay);
    chk("launch_valid", core_valid, 1'b1);
    repeat (delay) begin
      @(negedge clk);
      chk("launch_valid_hold", core_valid, 1'b1);
      chk("launch_s_ready", s_ready, 1'b0);
      chk("launch_fm_wr_en", load_fm_wr_en, 4'd0);
      chk("launch_gd_wr_en", load_gd_wr_en, 4'd0);
    end
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    chk("run_valid_low", core_valid, 1'b0);
    chk("run_busy", busy, 1'b1);
  endtask

  task automatic end_job();
    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    @(negedge clk);
    chk("done_low", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fm_words_i = 9'd0; gd_words_i = 7'd0;
    bit_mode_i = 1'b0; is_diff_i = 1'b0; s_valid = 1'b0; s_data = 72'd0;
    core_ready = 1'b0; core_finish = 1'b0;

    jobs[0] = '{fm_in: 9'd2, gd_in: 7'd1,   tog: 1'b0, bm: 1'b1, df: 1'b0, exp_fm_n: 2, exp_gd_n: 1};
    jobs[1] = '{fm_in: 9'd2, gd_in: 7'd1,   tog: 1'b1, bm: 1'b0, df: 1'b1, exp_fm_n: 2, exp_gd_n: 1};
    jobs[2] = '{fm_in: 9'd0, gd_in: 7'd3,   tog: 1'b0, bm: 1'b1, df: 1'b1, exp_fm_n: 0, exp_gd_n: 3};
    jobs[3] = '{fm_in: 9'd3, gd_in: 7'd0,   tog: 1'b1, bm: 1'b0, df: 1'b0, exp_fm_n: 3, exp_gd_n: 0};
    jobs[4] = '{fm_in: 9'd5, gd_in: 7'd100, tog: 1'b0, bm: 1'b1, df: 1'b0, exp_fm_n: 5, exp_gd_n: 64};

    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Table-driven load+run jobs.
    for (int j = 0; j < 5; j++) begin
      start_job(int'(jobs[j].fm_in), int'(jobs[j].gd_in), jobs[j].bm, jobs[j].df);
      run_stream(jobs[j].exp_fm_n, jobs[j].exp_gd_n, jobs[j].tog,
                 PE * (jobs[j].exp_fm_n + jobs[j].exp_gd_n));
      launch_job(0);
      end_job();
    end

    // Empty job goes straight to launch; core held off for five cycles.
    start_job(0, 0, 1'b0, 1'b1);
    chk("empty_s_ready", s_ready, 1'b0);
    chk("empty_valid_first", core_valid, 1'b0);
    @(negedge clk);
    launch_job(4);
    end_job();

    // core_finish during LOAD_FM is ignored.
    start_job(1, 1, 1'b1, 1'b1);
    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
    chk("early_finish_busy", busy, 1'b1);
    chk("early_finish_done", done, 1'b0);
    chk("early_finish_s_ready", s_ready, 1'b1);
    run_stream(1, 1, 1'b0, 8);
    launch_job(1);
    end_job();

    // Reset after 3 of 8 fm beats, then a fresh job restarts at col0 a0.
    start_job(8, 1, 1'b1, 1'b1);
    run_stream(8, 1, 1'b0, 3);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_job(8, 1, 1'b0, 1'b1);
    run_stream(8, 1, 1'b0, 36);
    launch_job(0);
    end_job();

    // start during RUN is ignored; next job picks up freshly sampled values.
    start_job(1, 1, 1'b1, 1'b0);
    run_stream(1, 1, 1'b1, 8);
    launch_job(2);
    fm_words_i = 9'd2; gd_words_i = 7'd2; bit_mode_i = 1'b0; is_diff_i = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_start_busy", busy, 1'b1);
    chk("run_start_s_ready", s_ready, 1'b0);
    chk("run_start_bit_mode", core_bit_mode_i, 1'b1);
    chk("run_start_is_diff", core_is_diff_i, 1'b0);
    chk("run_start_valid", core_valid, 1'b0);
    @(negedge clk);
    chk("run_start_s_ready2", s_ready, 1'b0);
    end_job();
    start_job(2, 2, 1'b0, 1'b1);
    run_stream(2, 2, 1'b0, 16);
    launch_job(0);
    end_job();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
